wave_playback: RTL and testbench

Reader side of the waveform value-change record stream. Consumes time-stamped value-change records (time, signal id, value) over a valid/ready interface and re-drives a bank of single-bit signals at the recorded simulation times. Used to replay captured activity, such as clock and inverter-chain toggles, into a DUT or checker. An internal simulation-time counter advances only while no record is due, so multiple changes at one timestamp are applied before time moves on.

---
 rtl/wave_playback_pkg.sv | 27 ++
 rtl/playback_time_ctr.sv | 22 ++
 rtl/wave_playback.sv | 122 ++++++++++++
 tb/tb_wave_playback.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_playback_pkg.sv
// rtl/wave_playback_pkg.sv - shared types and defaults for the waveform playback reader
package wave_playback_pkg;

  localparam int DEF_NUM_SIGS = 8;
  localparam int DEF_TIME_W   = 32;
  localparam int MAX_TIME_W   = 64;
  localparam int MAX_ID_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Record fields are widened to the largest supported sizes so one type serves every build.
  typedef struct packed {
    logic [MAX_TIME_W-1:0] tstamp;
    logic [MAX_ID_W-1:0]   id;
    logic                  val;
    logic                  last;
  } rec_t;

  function automatic logic id_in_range(input logic [MAX_ID_W-1:0] id, input int num_sigs);
    return ({24'd0, id} < 32'(num_sigs));
  endfunction

endpackage

// File: rtl/playback_time_ctr.sv
// rtl/playback_time_ctr.sv - saturating playback time counter with clear and advance
module playback_time_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/wave_playback.sv
// rtl/wave_playback.sv - replays time-stamped value-change records onto a signal bank
// Optional change counter output chg_count enabled by WAVE_PLAYBACK_CHG_CNT_EN.
module wave_playback
  import wave_playback_pkg::*;
#(
  parameter int                  NUM_SIGS = DEF_NUM_SIGS,
  parameter int                  ID_W     = $clog2(NUM_SIGS),
  parameter int                  TIME_W   = DEF_TIME_W,
  parameter logic [NUM_SIGS-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pause,
  input  logic                rec_valid,
  output logic                rec_ready,
  input  logic [TIME_W-1:0]   rec_time,
  input  logic [ID_W-1:0]     rec_id,
  input  logic                rec_val,
  input  logic                rec_last,
  output logic [NUM_SIGS-1:0] sig_out,
  output logic [TIME_W-1:0]   cur_time,
  output logic                busy,
  output logic                done,
  output logic                late_err,
  output logic                id_err
`ifdef WAVE_PLAYBACK_CHG_CNT_EN
  ,
  output logic [31:0]         chg_count
`endif
);

  state_t state;
  rec_t   rec;
  logic   due;
  logic   accept;
  logic   in_range;
  logic   advance;

  always_comb begin
    rec      = '{tstamp: MAX_TIME_W'(rec_time), id: MAX_ID_W'(rec_id), val: rec_val, last: rec_last};
    due      = (rec.tstamp <= MAX_TIME_W'(cur_time));
    // A start pulse wins over any record presented in the same cycle.
    accept   = (state == RUN) && !start && !pause && rec_valid && due;
    in_range = id_in_range(rec.id, NUM_SIGS);
    advance  = (state == RUN) && !start && !pause && !accept;
  end

  assign rec_ready = accept;

  playback_time_ctr #(
    .W(TIME_W)
  ) u_time_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .advance (advance),
    .count   (cur_time)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sig_out  <= INIT_VAL;
      busy     <= 1'b0;
      done     <= 1'b0;
      late_err <= 1'b0;
      id_err   <= 1'b0;
    end else if (start) begin
      state    <= RUN;
      sig_out  <= INIT_VAL;
      busy     <= 1'b1;
      done     <= 1'b0;
      late_err <= 1'b0;
      id_err   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (in_range) begin
              sig_out[rec_id] <= rec.val;
            end else begin
              id_err <= 1'b1;
            end
            if (rec.tstamp < MAX_TIME_W'(cur_time)) begin
              late_err <= 1'b1;
            end
            if (rec.last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef WAVE_PLAYBACK_CHG_CNT_EN
  logic is_change;

  always_comb begin
    is_change = 1'b0;
    if (accept && in_range) begin
      is_change = (sig_out[rec_id] != rec.val);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_count <= '0;
    end else if (start) begin
      chg_count <= '0;
    end else if (is_change && (chg_count != 32'hFFFF_FFFF)) begin
      chg_count <= chg_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wave_playback.sv
// tb/tb_wave_playback.sv - scoreboard bench for wave_playback (6 signals, 8-bit time)
module tb_wave_playback;

  localparam int NS = 6;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          rec_valid = 1'b0;
  logic          rec_ready;
  logic [TW-1:0] rec_time = '0;
  logic [2:0]    rec_id = '0;
  logic          rec_val = 1'b0;
  logic          rec_last = 1'b0;
  logic [NS-1:0] sig_out;
  logic [TW-1:0] cur_time;
  logic          busy;
  logic          done;
  logic          late_err;
  logic          id_err;
`ifdef WAVE_PLAYBACK_CHG_CNT_EN
  logic [31:0]   chg_count;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [NS-1:0] sig;
    logic [TW-1:0] t;
  } exp_t;

  exp_t          q[$];
  logic [NS-1:0] m_sig = '0;
  logic [TW-1:0] m_time = '0;

  wave_playback #(
    .NUM_SIGS (NS),
    .TIME_W   (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_time  (rec_time),
    .rec_id    (rec_id),
    .rec_val   (rec_val),
    .rec_last  (rec_last),
    .sig_out   (sig_out),
    .cur_time  (cur_time),
    .busy      (busy),
    .done      (done),
    .late_err  (late_err),
    .id_err    (id_err)
`ifdef WAVE_PLAYBACK_CHG_CNT_EN
    ,
    .chg_count (chg_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_time = '0;
    m_sig = '0;
  endtask

  // Model: a record is applied at max(its time, time of the previous acceptance).
  task automatic drive_rec(input logic [TW-1:0] t, input int id, input logic v, input logic last);
    if (t > m_time) m_time = t;
    if (id < NS) m_sig[id] = v;
    q.push_back('{sig: m_sig, t: m_time});
    rec_time = t;
    rec_id = 3'(id);
    rec_val = v;
    rec_last = last;
    rec_valid = 1'b1;
  endtask

  task automatic wait_accept(output int waited);
    exp_t          e;
    logic [TW-1:0] acc_t;
    bit            timed_out;
    waited = 0;
    timed_out = 0;
    #1;
    while (!rec_ready && !timed_out) begin
      @(negedge clk);
      #1;
      waited++;
      if (waited > 600) timed_out = 1;
    end
    if (timed_out) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout rec_time=%0d cur_time=%0d", rec_time, cur_time);
      rec_valid = 1'b0;
      if (q.size() > 0) e = q.pop_front();
      waited = -1;
    end else begin
      acc_t = cur_time;
      @(negedge clk);
      rec_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (acc_t !== e.t) begin
        failures++;
        $display("FAIL accept_time got=%0d exp=%0d", acc_t, e.t);
      end
      checks++;
      if (sig_out !== e.sig) begin
        failures++;
        $display("FAIL sig_out_after_accept got=%b exp=%b", sig_out, e.sig);
      end
    end
  endtask

  task automatic send(input logic [TW-1:0] t, input int id, input logic v, input logic last,
                      output int waited);
    drive_rec(t, id, v, last);
    wait_accept(waited);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({sig_out, cur_time, busy, done, late_err, id_err, rec_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {sig_out, cur_time, busy, done, late_err, id_err, rec_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rec_time = '0;
    rec_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (rec_ready !== 1'b0 || cur_time !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got=%b/%0d/%b exp=0/0/0", rec_ready, cur_time, busy);
    end
    rec_valid = 1'b0;
  endtask

  task automatic test_basic();
    int w;
    do_start();
    send(8'd5, 0, 1'b1, 1'b0, w);
    send(8'd10, 0, 1'b0, 1'b0, w);
    send(8'd15, 0, 1'b1, 1'b1, w);
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || late_err !== 1'b0 || cur_time !== 8'd15) begin
      failures++;
      $display("FAIL basic_done got=%b/%b/%b/%0d exp=1/0/0/15", done, busy, late_err, cur_time);
    end
  endtask

  task automatic test_same_time();
    int w;
    do_start();
    send(8'd7, 1, 1'b1, 1'b0, w);
    send(8'd7, 2, 1'b1, 1'b0, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL same_time_gap2 got=%0d exp=0", w);
    end
    send(8'd7, 3, 1'b1, 1'b0, w);
    checks++;
    if (w !== 0 || cur_time !== 8'd7) begin
      failures++;
      $display("FAIL same_time_gap3 got=%0d/%0d exp=0/7", w, cur_time);
    end
    @(negedge clk);
    checks++;
    if (cur_time !== 8'd8 || sig_out !== 6'b001110) begin
      failures++;
      $display("FAIL same_time_final got=%0d/%b exp=8/001110", cur_time, sig_out);
    end
  endtask

  task automatic test_pause();
    int cnt;
    int w;
    do_start();
    cnt = 0;
    while (cur_time != 8'd100 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cur_time !== 8'd100) begin
      failures++;
      $display("FAIL pause_reach got=%0d exp=100", cur_time);
    end
    pause = 1'b1;
    m_time = 8'd100;
    drive_rec(8'd100, 5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rec_ready !== 1'b0 || cur_time !== 8'd100) begin
        failures++;
        $display("FAIL pause_hold cycle=%0d got=%b/%0d exp=0/100", i, rec_ready, cur_time);
      end
    end
    pause = 1'b0;
    wait_accept(w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL pause_release got=%0d exp=0", w);
    end
  endtask

  task automatic test_late();
    int w;
    do_start();
    send(8'd50, 4, 1'b1, 1'b0, w);
    send(8'd40, 4, 1'b0, 1'b0, w);
    checks++;
    if (w !== 0 || late_err !== 1'b1) begin
      failures++;
      $display("FAIL late_set got=%0d/%b exp=0/1", w, late_err);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (late_err !== 1'b1) begin
      failures++;
      $display("FAIL late_sticky got=%b exp=1", late_err);
    end
    do_start();
    checks++;
    if (late_err !== 1'b0 || cur_time !== '0 || sig_out !== '0) begin
      failures++;
      $display("FAIL late_clear got=%b/%0d/%b exp=0/0/0", late_err, cur_time, sig_out);
    end
  endtask

  task automatic test_id_err_and_async_reset();
    int w;
    do_start();
    send(8'd4, 6, 1'b1, 1'b1, w);
    checks++;
    if (id_err !== 1'b1 || done !== 1'b1 || sig_out !== '0) begin
      failures++;
      $display("FAIL id_last got=%b/%b/%b exp=1/1/000000", id_err, done, sig_out);
    end
    do_start();
    send(8'd20, 0, 1'b1, 1'b0, w);
    send(8'd10, 1, 1'b1, 1'b0, w);
    send(8'd3, 7, 1'b0, 1'b0, w);
    checks++;
    if (id_err !== 1'b1 || late_err !== 1'b1 || sig_out !== 6'b000011) begin
      failures++;
      $display("FAIL id_drop got=%b/%b/%b exp=1/1/000011", id_err, late_err, sig_out);
    end
    rec_time = 8'd200;
    rec_id = 3'd2;
    rec_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sig_out, cur_time, busy, done, late_err, id_err, rec_ready} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {sig_out, cur_time, busy, done, late_err, id_err, rec_ready});
    end
    rec_valid = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    int cnt;
    int w;
    do_start();
    cnt = 0;
    while (cur_time != 8'hFF && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (cur_time !== 8'hFF) begin
      failures++;
      $display("FAIL time_saturate got=%0d exp=255", cur_time);
    end
    m_time = 8'hFF;
    send(8'hFF, 2, 1'b1, 1'b1, w);
    checks++;
    if (done !== 1'b1 || late_err !== 1'b0 || cur_time !== 8'hFF) begin
      failures++;
      $display("FAIL max_time_rec got=%b/%b/%0d exp=1/0/255", done, late_err, cur_time);
    end
  endtask

`ifdef WAVE_PLAYBACK_CHG_CNT_EN
  task automatic test_chg_count();
    int w;
    do_start();
    checks++;
    if (chg_count !== 32'd0) begin
      failures++;
      $display("FAIL chg_clear got=%0d exp=0", chg_count);
    end
    send(8'd1, 0, 1'b1, 1'b0, w);
    send(8'd2, 0, 1'b1, 1'b0, w);
    send(8'd3, 0, 1'b0, 1'b1, w);
    checks++;
    if (chg_count !== 32'd2) begin
      failures++;
      $display("FAIL chg_count got=%0d exp=2", chg_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_same_time();
    test_pause();
    test_late();
    test_id_err_and_async_reset();
    test_saturate();
`ifdef WAVE_PLAYBACK_CHG_CNT_EN
    test_chg_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
